// File: rtl/mic_adc_spi_rx.sv
// SPI master and sample-rate generator for an ADCS7476-class 12-bit ADC.
// Starts one conversion per SAMPLE_PERIOD clocks and presents a held sample with a valid strobe.
module mic_adc_spi_rx #(
    parameter int CLK_DIV       = 3,
    parameter int CS_SETUP      = 2,
    parameter int QUIET         = 5,
    parameter int SAMPLE_PERIOD = 6250,
    parameter bit SIGNED_OUT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sdata,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] adc_data,
    output logic        sample_valid,
    output logic        frame_err,
    output logic [1:0]  fsm_state
);

    localparam int CNT_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CYC_MAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    // A new frame must never be requested while the previous one is still running.
    if (SAMPLE_PERIOD < 1 + CS_SETUP + 32 * CLK_DIV + QUIET) begin : g_period_check
        $error("SAMPLE_PERIOD too short for one frame plus cs_n quiet time");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   period_cnt;
    logic               tick;
    logic [CYC_W-1:0]   cyc_cnt;
    logic               phase;
    logic [3:0]         bit_cnt;
    logic [15:0]        shift_reg;
    logic [15:0]        shift_next;
    logic               sdata_q;
    logic               hi_last;
    logic               frame_end;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (!enable) begin
            period_cnt <= '0;
        end else if (period_cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign tick       = enable && (period_cnt == '0);
    assign hi_last    = (state == SHIFT) && phase && (cyc_cnt == CYC_W'(CLK_DIV - 1));
    assign frame_end  = hi_last && (bit_cnt == 4'd15);
    assign shift_next = {shift_reg[14:0], sdata_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = SETUP;
            SETUP:   if (cyc_cnt == CYC_W'(CS_SETUP - 1)) next_state = SHIFT;
            SHIFT:   if (frame_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // phase 0 = sclk low half, phase 1 = sclk high half; counters restart on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (state != next_state) begin
            cyc_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (state == SETUP) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end else if (state == SHIFT) begin
            if (cyc_cnt == CYC_W'(CLK_DIV - 1)) begin
                cyc_cnt <= '0;
                phase   <= ~phase;
                if (phase) bit_cnt <= bit_cnt + 1'b1;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // sample_valid / frame_err are single-cycle strobes with no back-pressure: the consumer must
    // take adc_data in the cycle sample_valid is high; adc_data then holds until the next strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdata_q      <= 1'b0;
            shift_reg    <= '0;
            adc_data     <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sdata_q      <= sdata;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (hi_last) shift_reg <= shift_next;
            if (frame_end) begin
                if (shift_next[15:12] == 4'h0) begin
                    adc_data     <= SIGNED_OUT ? {~shift_next[11], shift_next[10:0]}
                                               : shift_next[11:0];
                    sample_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cs_n = 1'b1;
        sclk = 1'b1;
        case (state)
            SETUP:   cs_n = 1'b0;
            SHIFT: begin
                cs_n = 1'b0;
                sclk = phase;
            end
            default: begin
                cs_n = 1'b1;
                sclk = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mic_adc_spi_rx.sv
// Bench for mic_adc_spi_rx: an ADC model feeds two DUTs (signed and raw output) sharing one SPI bus.
`timescale 1ns/1ps
module tb_mic_adc_spi_rx;

    localparam int CLK_DIV       = 3;
    localparam int CS_SETUP      = 2;
    localparam int QUIET         = 5;
    localparam int SAMPLE_PERIOD = 6250;
    localparam int LAT           = 1 + CS_SETUP + 32 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sdata = 1'b0;
    logic        cs_n, sclk, sample_valid, frame_err;
    logic [11:0] adc_data;
    logic [1:0]  fsm_state;
    logic        cs_n_raw, sclk_raw, raw_valid, raw_err;
    logic [11:0] raw_data;
    logic [1:0]  raw_state;

    mic_adc_spi_rx #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .QUIET(QUIET),
                     .SAMPLE_PERIOD(SAMPLE_PERIOD), .SIGNED_OUT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .sdata(sdata),
        .cs_n(cs_n), .sclk(sclk), .adc_data(adc_data),
        .sample_valid(sample_valid), .frame_err(frame_err), .fsm_state(fsm_state)
    );

    mic_adc_spi_rx #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .QUIET(QUIET),
                     .SAMPLE_PERIOD(SAMPLE_PERIOD), .SIGNED_OUT(1'b0)) u_raw (
        .clk(clk), .rst(rst), .enable(enable), .sdata(sdata),
        .cs_n(cs_n_raw), .sclk(sclk_raw), .adc_data(raw_data),
        .sample_valid(raw_valid), .frame_err(raw_err), .fsm_state(raw_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ADC model ----------------
    logic [15:0] frame_q[$];
    logic [15:0] cur_frame = 16'h0;
    int          nbit = 0;

    always @(negedge cs_n) begin
        cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0000;
        nbit = 0;
    end

    always @(negedge sclk) begin
        if (!cs_n && nbit < 16) begin
            sdata = cur_frame[15 - nbit];
            nbit++;
        end
    end

    // ---------------- bus / output monitor ----------------
    int          cs_fall_q[$];
    int          valid_cyc_q[$];
    int          err_cyc_q[$];
    int          fall_cnt_q[$];
    logic [11:0] data_q[$];
    logic [11:0] raw_q[$];
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_sv = 1'b0, prev_fe = 1'b0;
    int          nfall = 0, first_fall = -1, last_fall = 0, rise_cyc = 0;
    bit          seen_rise = 1'b0;
    int          idle_viol = 0, period_viol = 0, pulse_viol = 0, quiet_viol = 0;

    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            cs_fall_q.push_back(cyc);
            nfall = 0;
            if (seen_rise && (cyc - rise_cyc) < QUIET) quiet_viol++;
        end
        if (!prev_cs && cs_n) begin
            fall_cnt_q.push_back(nfall);
            rise_cyc  = cyc;
            seen_rise = 1'b1;
        end
        if (!cs_n && prev_sclk && !sclk) begin
            if (nfall == 0) first_fall = cyc;
            else if (cyc - last_fall != 2 * CLK_DIV) period_viol++;
            last_fall = cyc;
            nfall++;
        end
        if (cs_n && !sclk) idle_viol++;
        if (sample_valid) begin
            valid_cyc_q.push_back(cyc);
            data_q.push_back(adc_data);
        end
        if (frame_err) err_cyc_q.push_back(cyc);
        if (raw_valid) raw_q.push_back(raw_data);
        if ((sample_valid && frame_err) || (sample_valid && prev_sv) || (frame_err && prev_fe))
            pulse_viol++;
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_sv   = sample_valid;
        prev_fe   = frame_err;
    end

    // ---------------- scoreboard / reference ----------------
    int          checks = 0;
    int          errors = 0;
    logic [11:0] model_adc = 12'h000;
    logic [11:0] model_raw = 12'h000;
    logic [11:0] exp_q[$];

    // Offset binary to two's complement: code minus mid-scale, wrapped to 12 bits.
    function automatic logic [11:0] ref_signed(input logic [11:0] raw);
        int v;
        v = (int'(raw) - 2048 + 4096) % 4096;
        return 12'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        cs_fall_q.delete();
        valid_cyc_q.delete();
        err_cyc_q.delete();
        fall_cnt_q.delete();
        data_q.delete();
        raw_q.delete();
        first_fall = -1;
    endtask

    // One conversion triggered by a single-cycle enable pulse, then all observations checked.
    task automatic one_shot(input logic [15:0] frame, input string tag);
        int          t;
        logic [11:0] exp_s;
        clear_mon();
        frame_q.push_back(frame);
        enable = 1'b1;
        t = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cycles(LAT + 12);
        check({tag, "_cs_fall"}, 32'((cs_fall_q.size() == 1) ? cs_fall_q[0] : -1), 32'(t + 1));
        check({tag, "_first_sclk"}, 32'(first_fall), 32'(t + 1 + CS_SETUP));
        check({tag, "_sclk_count"}, 32'((fall_cnt_q.size() > 0) ? fall_cnt_q[$] : -1), 32'd16);
        if (frame[15:12] == 4'h0) begin
            exp_s     = ref_signed(frame[11:0]);
            model_adc = exp_s;
            model_raw = frame[11:0];
            check({tag, "_valid_cyc"}, 32'((valid_cyc_q.size() == 1) ? valid_cyc_q[0] : -1),
                  32'(t + LAT));
            check({tag, "_data"}, 32'((data_q.size() > 0) ? data_q[0] : 12'hxxx), 32'(exp_s));
            check({tag, "_raw_data"}, 32'((raw_q.size() > 0) ? raw_q[0] : 12'hxxx),
                  32'(frame[11:0]));
            check({tag, "_no_err"}, 32'(err_cyc_q.size()), 32'd0);
        end else begin
            check({tag, "_err_cyc"}, 32'((err_cyc_q.size() == 1) ? err_cyc_q[0] : -1),
                  32'(t + LAT));
            check({tag, "_no_valid"}, 32'(valid_cyc_q.size()), 32'd0);
            check({tag, "_held"}, 32'(adc_data), 32'(model_adc));
            check({tag, "_raw_held"}, 32'(raw_data), 32'(model_raw));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          t;
        logic [11:0] r;
        rst    = 1'b0;
        enable = 1'b0;
        wait_cycles(4);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_adc_data", 32'(adc_data), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        wait_cycles(4);

        one_shot(16'h0800, "basic");
        one_shot(16'h0FFF, "full_scale");
        one_shot(16'h0000, "zero_scale");
        one_shot(16'h0A5C, "code_a5c");
        for (int i = 0; i < 4; i++) one_shot({4'h0, 12'($urandom_range(0, 4095))}, "rand_good");

        // Five periods of free-running conversions.
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            r = 12'($urandom_range(0, 4095));
            frame_q.push_back({4'h0, r});
            exp_q.push_back(ref_signed(r));
            model_raw = r;
        end
        enable = 1'b1;
        t = cyc;
        wait_cycles(5 * SAMPLE_PERIOD);
        enable = 1'b0;
        wait_cycles(LAT + 20);
        check("rate_frames", 32'(cs_fall_q.size()), 32'd5);
        check("rate_valids", 32'(valid_cyc_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < cs_fall_q.size() && k < valid_cyc_q.size(); k++) begin
            check("rate_cs_fall", 32'(cs_fall_q[k]), 32'(t + 1 + k * SAMPLE_PERIOD));
            check("rate_valid_cyc", 32'(valid_cyc_q[k]), 32'(t + LAT + k * SAMPLE_PERIOD));
            check("rate_data", 32'(data_q[k]), 32'(exp_q[k]));
        end
        model_adc = exp_q[4];

        // Enable dropped during bit 7: frame still completes, nothing follows.
        clear_mon();
        r = 12'($urandom_range(0, 4095));
        frame_q.push_back({4'h0, r});
        enable = 1'b1;
        t = cyc;
        wait_cycles(1 + CS_SETUP + 7 * 2 * CLK_DIV + 1);
        enable = 1'b0;
        wait_cycles(400);
        check("drop_valid_cyc", 32'((valid_cyc_q.size() == 1) ? valid_cyc_q[0] : -1), 32'(t + LAT));
        check("drop_data", 32'((data_q.size() > 0) ? data_q[0] : 12'hxxx), 32'(ref_signed(r)));
        check("drop_no_more_cs", 32'(cs_fall_q.size()), 32'd1);
        model_adc = ref_signed(r);
        model_raw = r;
        one_shot({4'h0, 12'($urandom_range(0, 4095))}, "reenable");

        // Leading nibble error after a good sample.
        one_shot(16'h0456, "pre_err");
        one_shot(16'h4123, "nibble_err");
        one_shot({4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))}, "rand_err");

        // Asynchronous reset in the middle of bit 9.
        clear_mon();
        frame_q.push_back(16'h0ABC);
        enable = 1'b1;
        t = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cycles((t + 1 + CS_SETUP + 9 * 2 * CLK_DIV + 2) - cyc);
        check("pre_rst_cs_low", 32'(cs_n), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_cs_n", 32'(cs_n), 32'd1);
        check("async_sclk", 32'(sclk), 32'd1);
        check("async_adc_data", 32'(adc_data), 32'd0);
        check("async_raw_data", 32'(raw_data), 32'd0);
        check("async_valid", 32'(sample_valid), 32'd0);
        model_adc = 12'h000;
        model_raw = 12'h000;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(3);
        check("abort_no_output", 32'(valid_cyc_q.size() + err_cyc_q.size()), 32'd0);
        one_shot({4'h0, 12'($urandom_range(0, 4095))}, "post_rst");

        check("sclk_idle_high", 32'(idle_viol), 32'd0);
        check("sclk_period", 32'(period_viol), 32'd0);
        check("pulse_shape", 32'(pulse_viol), 32'd0);
        check("cs_quiet", 32'(quiet_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_adc_spi_rx.md
Name: mic_adc_spi_rx

Overview:
- SPI master and sample-rate generator for the 12-bit microphone ADC (ADCS7476-class: 16-bit frame of 4 leading zeros, then 12 data bits, MSB first).
- Triggers one conversion every SAMPLE_PERIOD clocks and deserialises the frame.
- Presents a held 12-bit sample with a one-cycle valid strobe.
- Sits directly upstream of the audio-processing top and drives its adc_data input.

Parameters:
- CLK_DIV, 3: clk cycles per sclk half-period; sclk = clk/(2*CLK_DIV).
- CS_SETUP, 2: clk cycles from cs_n falling to first sclk falling edge.
- QUIET, 5: minimum clk cycles cs_n stays high between frames.
- SAMPLE_PERIOD, 6250: clk cycles between conversion starts (100 MHz / 16 kHz).
- SIGNED_OUT, 1: 1 converts offset-binary to two's complement; 0 passes raw code.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  1 = run periodic conversions
- sdata  in  1  ADC serial data
- cs_n  out  1  ADC chip select, active-low
- sclk  out  1  ADC serial clock, idles high
- adc_data  out  12  last good sample, held between updates
- sample_valid  out  1  one-cycle pulse when adc_data updates
- frame_err  out  1  one-cycle pulse when leading nibble is not 0000

Behaviour:
- Reset (rst=0, asynchronous):
  - cs_n=1, sclk=1, adc_data=0, sample_valid=0, frame_err=0.
  - Period counter=0, FSM=IDLE, shift register cleared.
  - Reset mid-frame aborts the frame immediately, with no partial output.
- Compile-time check (elaboration error if violated): SAMPLE_PERIOD >= 1+CS_SETUP+32*CLK_DIV+QUIET.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - tick = (counter==0 && enable).
- sdata is registered in one input flop (sdata_q) before use.
- FSM:
  - IDLE: cs_n=1, sclk=1. On tick -> SETUP; cs_n goes low on the next cycle.
  - SETUP: cs_n=0, sclk=1, CS_SETUP cycles -> SHIFT.
  - SHIFT: 16 sclk periods, each CLK_DIV cycles low then CLK_DIV cycles high.
    - On the last clk cycle of each high phase, shift sdata_q into a 16-bit register, MSB first.
    - Bit counter counts 0..15.
    - After the 16th high phase -> DONE.
  - DONE (1 cycle): cs_n=1, sclk=1.
    - If shift[15:12]==0: adc_data <= SIGNED_OUT ? {~shift[11],shift[10:0]} : shift[11:0], and sample_valid=1.
    - Otherwise frame_err=1 and adc_data is unchanged.
    - -> IDLE.
- Latency: sample_valid asserts exactly 1+CS_SETUP+32*CLK_DIV cycles after the tick cycle (99 with defaults).
- enable deasserted mid-frame: the current frame completes and outputs normally; no new tick occurs.
- enable reasserted: the tick fires in the same cycle; the counter restarts from 0.
- A tick arriving while not IDLE is impossible given the compile-time check; it is ignored by design.
- sample_valid and frame_err are never high in the same cycle.
- Neither pulse lasts longer than 1 cycle.

Test Plan:
- Basic conversion: reset, enable=1, ADC model returns 0000_1000_0000_0000 (raw 0x800).
  - Expect: cs_n low 1 cycle after tick; 16 sclk falling edges, each period 6 clk; sample_valid at tick+99; adc_data=0x000 (SIGNED_OUT=1).
- Code extremes, SIGNED_OUT=1:
  - raw 0xFFF -> adc_data=0x7FF.
  - raw 0x000 -> adc_data=0x800.
  - Raw 0xA5C with SIGNED_OUT=0 -> 0xA5C.
- Sample rate: enable for 5 periods.
  - Expect: tick-to-tick and valid-to-valid spacing exactly 6250 cycles.
  - cs_n high time >= QUIET between frames; sclk steady high whenever cs_n=1.
- Frame error: model drives leading nibble 0100 with data 0x123, after a good sample of 0x456.
  - Expect: frame_err 1 cycle, no sample_valid, adc_data stays at the prior value.
- Enable drop: deassert enable at bit 7 of a frame.
  - Expect: frame completes with valid; no further cs_n activity.
  - On re-enable, cs_n falls 1 cycle after the enable cycle.
- Async reset mid-SHIFT: assert rst low between clock edges at bit 9.
  - Expect: cs_n=1, sclk=1, adc_data=0 immediately, without waiting for a clock edge.
  - After release, the next full frame is captured correctly.
